// File: rtl/boot_seq_ctrl_pkg.sv
// rtl/boot_seq_ctrl_pkg.sv - shared boot sequencer constants and state encodings
package boot_seq_ctrl_pkg;

    localparam int BOOT_ADDR_WIDTH = 8;
    localparam int BOOT_ADDR_NUM   = 256;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_FILL    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    // States in which a new start is honoured and busy is low.
    function automatic logic is_quiet(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR);
    endfunction

endpackage

// File: rtl/boot_timeout_cnt.sv
// rtl/boot_timeout_cnt.sv - saturating run-cycle counter, timeout compare, core_valid edge detect
module boot_timeout_cnt #(
    parameter int CYC_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 run_en,
    input  logic                 core_valid,
    output logic [CYC_WIDTH-1:0] run_cycles,
    output logic                 valid_rise,
    output logic                 timeout
);

    localparam logic [CYC_WIDTH-1:0] CYC_ONE   = CYC_WIDTH'(1);
    localparam logic [CYC_WIDTH-1:0] CYC_LIMIT = CYC_WIDTH'(TIMEOUT_CYC);

    logic                 valid_q;
    logic [CYC_WIDTH-1:0] cnt_next;

    assign cnt_next   = (&run_cycles) ? run_cycles : run_cycles + CYC_ONE;
    // valid_q tracks core_valid in every state, so a level that is already
    // high when RUN begins never looks like a rising edge.
    assign valid_rise = core_valid & ~valid_q;
    // The exiting RUN cycle is itself counted, so the compare looks at the
    // post-increment value: RUN lasts exactly TIMEOUT_CYC cycles.
    assign timeout    = run_en & (cnt_next == CYC_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            run_cycles <= '0;
        end else begin
            valid_q <= core_valid;
            if (clear) begin
                run_cycles <= '0;
            end else if (run_en) begin
                run_cycles <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/boot_seq_ctrl.sv
// rtl/boot_seq_ctrl.sv - instruction-memory boot sequencer: load, zero-fill, release, timed run
module boot_seq_ctrl
    import boot_seq_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = BOOT_ADDR_WIDTH,
    parameter int ADDR_NUM    = BOOT_ADDR_NUM,
    parameter int RELEASE_CYC = 2,
    parameter int TIMEOUT_CYC = 65535,
    parameter int CYC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   code_size,
    input  logic                  src_valid,
    input  logic [31:0]           src_data,
    output logic                  src_ready,
    output logic                  boot_up,
    output logic [ADDR_WIDTH-1:0] boot_addr,
    output logic [31:0]           boot_datai,
    input  logic                  core_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CYC_WIDTH-1:0]  run_cycles
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH:0] CNT_NUM  = CW'(ADDR_NUM);
    localparam logic [ADDR_WIDTH:0] CNT_LAST = CW'(ADDR_NUM - 1);

    localparam int RW = 16;
    localparam logic [RW-1:0] REL_ONE   = RW'(1);
    localparam logic [RW-1:0] REL_LIMIT = RW'(RELEASE_CYC);

    logic [2:0]          state;
    logic [ADDR_WIDTH:0] size;
    logic [ADDR_WIDTH:0] size_in;
    logic [ADDR_WIDTH:0] addr_cnt;
    logic [RW-1:0]       rel_cnt;
    logic                start_ok;
    logic                valid_rise;
    logic                timeout;

    assign size_in   = (code_size > CNT_NUM) ? CNT_NUM : code_size;
    assign start_ok  = start & is_quiet(state);
    assign src_ready = (state == ST_LOAD);
    assign busy      = ~is_quiet(state);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERR);

    boot_timeout_cnt #(
        .CYC_WIDTH  (CYC_WIDTH),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .run_en    (state == ST_RUN),
        .core_valid(core_valid),
        .run_cycles(run_cycles),
        .valid_rise(valid_rise),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            size       <= '0;
            addr_cnt   <= '0;
            rel_cnt    <= '0;
            boot_up    <= 1'b0;
            boot_addr  <= '0;
            boot_datai <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        size     <= size_in;
                        addr_cnt <= '0;
                        state    <= (size_in != '0) ? ST_LOAD : ST_FILL;
                    end
                end
                ST_LOAD: begin
                    // Without a handshake the boot port keeps its last write;
                    // the core simply rewrites the same word.
                    if (src_valid) begin
                        boot_up    <= 1'b1;
                        boot_addr  <= addr_cnt[ADDR_WIDTH-1:0];
                        boot_datai <= src_data;
                        addr_cnt   <= addr_cnt + CNT_ONE;
                        if (addr_cnt == size - CNT_ONE) begin
                            rel_cnt <= '0;
                            state   <= (size < CNT_NUM) ? ST_FILL : ST_RELEASE;
                        end
                    end
                end
                ST_FILL: begin
                    boot_up    <= 1'b1;
                    boot_addr  <= addr_cnt[ADDR_WIDTH-1:0];
                    boot_datai <= '0;
                    addr_cnt   <= addr_cnt + CNT_ONE;
                    if (addr_cnt == CNT_LAST) begin
                        rel_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // The first RELEASE cycle still shows the final write, so
                    // boot_up is low for RELEASE_CYC cycles before RUN.
                    boot_up    <= 1'b0;
                    boot_addr  <= '0;
                    boot_datai <= '0;
                    if (rel_cnt == REL_LIMIT) begin
                        state <= ST_RUN;
                    end else begin
                        rel_cnt <= rel_cnt + REL_ONE;
                    end
                end
                ST_RUN: begin
                    if (valid_rise) begin
                        state <= ST_DONE;
                    end else if (timeout) begin
                        state <= ST_ERR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/boot_seq_ctrl.md
Name: boot_seq_ctrl

Overview:
- Sequencer for the core's instruction-memory boot port (boot_up / boot_addr / boot_datai) and its completion flag (valid).
- On start, streams CODE words from a ready/valid word source into addresses 0..code_size-1, zero-fills the rest of the ADDR_NUM space, releases boot_up, then times execution until the core raises valid.
- Sits between the program source (boot ROM/UART FIFO) and top_riscv_core; replaces bench-driven boot stimulus.

Parameters:
- ADDR_WIDTH, 8, boot address width
- ADDR_NUM, 256, instruction words written per boot, including zero-fill; must be ≤ 2^ADDR_WIDTH
- RELEASE_CYC, 2, idle cycles between boot_up falling and start of the RUN timeout window
- TIMEOUT_CYC, 65535, maximum RUN cycles before error
- CYC_WIDTH, 32, width of run-cycle counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle boot request; honoured only in IDLE, DONE or ERR
- code_size  in  ADDR_WIDTH+1  number of source words to load; sampled on accepted start; clamped to ADDR_NUM
- src_valid  in  1  source word available
- src_data  in  32  source instruction word
- src_ready  out  1  controller accepts word (LOAD state only)
- boot_up  out  1  to core: boot write enable
- boot_addr  out  ADDR_WIDTH  to core: boot write address
- boot_datai  out  32  to core: boot write data
- core_valid  in  1  core program-complete flag (same clock domain)
- busy  out  1  state ∉ {IDLE, DONE, ERR}
- done  out  1  level; high in DONE
- err  out  1  level; high in ERR (timeout)
- run_cycles  out  CYC_WIDTH  cycles spent in RUN for the last boot; saturating

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; core_valid edge register 0. Reset mid-boot aborts immediately with no further boot writes.
- States: IDLE, LOAD, FILL, RELEASE, RUN, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Latch size = min(code_size, ADDR_NUM); addr_cnt=0; run_cycles=0; clear done/err.
  - Next state is LOAD if size>0, else FILL.
- LOAD:
  - src_ready=1.
  - Each handshake (src_valid&src_ready) registers boot_up=1, boot_addr=addr_cnt, boot_datai=src_data on the next edge; addr_cnt++.
  - No handshake: boot outputs hold their previous values. The core rewrite is idempotent; before the first word, boot_up stays 0.
  - Handshake with addr_cnt==size-1: go to FILL if size<ADDR_NUM, else RELEASE.
- FILL: src_ready=0. One write per cycle: boot_up=1, boot_addr=addr_cnt, boot_datai=0, for addresses size..ADDR_NUM-1, then RELEASE.
- RELEASE: boot_up=0, boot_addr=0, boot_datai=0. Hold for RELEASE_CYC cycles, then RUN.
- RUN:
  - run_cycles increments each cycle, saturating at all-ones.
  - A rising edge of core_valid (registered edge detect; a level already high on entry does not count) moves to DONE.
  - run_cycles==TIMEOUT_CYC without an edge moves to ERR.
  - If the edge and the timeout occur in the same cycle, DONE wins.
- DONE/ERR: outputs held until the next start. start while busy is ignored.
- Latency: start to first boot write is 1 cycle plus source wait. Full boot occupies exactly ADDR_NUM write cycles when src_valid is held high.

Decomposition:
- Shared package/Def constants: state encodings (3-bit), ADDR_WIDTH/ADDR_NUM defaults shared with the core.
- One natural sub-module: boot_timeout_cnt, holding the saturating RUN counter, timeout compare and valid edge detect.

Test Plan:
- code_size=175, src_valid always 1, words 0x1000+i -> addr 0..174 get 0x1000+i, 175..255 get 0; boot_up high exactly 256 cycles; RELEASE 2 cycles.
- src_valid toggling 1/0 per cycle, code_size=4 -> boot_addr sequence 0,0,1,1,2,2,3 with data stable while stalled; then zero-fill from addr 4.
- code_size=0 -> no src_ready; 256 zero writes; code_size=300 -> clamped to 256 source words, no FILL.
- core_valid rises 37 cycles into RUN -> done=1, run_cycles=37; core_valid held high before RUN -> no DONE until it falls and rises again.
- TIMEOUT_CYC=100, core_valid never rises -> err=1 at run_cycles=100; restart start -> err cleared, boot repeats.
- rst_n asserted at addr 50 of LOAD -> all outputs 0 asynchronously; after release, new start reloads from addr 0.
